// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sender.
package ov7670_pkg;

  typedef enum logic [3:0] {
    RESEND,
    PWR_WAIT,
    LOAD,
    START,
    BIT,
    STOP,
    GAP,
    RST_WAIT,
    DONE
  } sccb_state_t;

  localparam logic [15:0] END_CMD    = 16'hFFFF;
  localparam logic [7:0]  COM7_ADDR  = 8'h12;
  localparam int          FRAME_BITS = 27;

  // Each byte is followed by a don't-care/ACK slot that is driven as '1' but released.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] dev,
                                                        input logic [15:0] cmd);
    return {dev, 1'b1, cmd[15:8], 1'b1, cmd[7:0], 1'b1};
  endfunction

  function automatic logic is_ack_slot(input logic [4:0] idx);
    return (idx == 5'd18) || (idx == 5'd9) || (idx == 5'd0);
  endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-period strobe for SCCB timing: one-cycle tick every CLK_DIV+1 clocks while not cleared.
module sccb_tick_gen #(
  parameter int CLK_DIV = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= CNT_W'(CLK_DIV);
    end else if (cnt == '0) begin
      cnt <= CNT_W'(CLK_DIV);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = !clear && (cnt == '0);

endmodule

// File: rtl/ov7670_sccb_sender.sv
// Walks the OV7670 command table and sends each entry as a 3-phase SCCB write.
// state    | meaning
// RESEND   | rewind the table, start power-up wait
// PWR_WAIT | camera power-up settling
// LOAD     | sample command; end marker -> DONE
// START    | SIOD falls with SIOC high, then SIOC falls
// BIT      | 27 bit slots, 4 quarters each, MSB first
// STOP     | SIOD rises with SIOC high
// GAP      | idle bus, then pulse advance
// RST_WAIT | settling after a COM7 soft reset
// DONE     | configuration complete, bus idle
module ov7670_sccb_sender
  import ov7670_pkg::*;
#(
  parameter int          CLK_DIV      = 63,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter int          POWERUP_WAIT = 2_500_000,
  parameter int          RESET_WAIT   = 25_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reconfig,
  input  logic [15:0] command,
  input  logic        finished,
  output logic        advance,
  output logic        resend,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe,
  output logic        busy,
  output logic        done
);

  localparam int WAIT_MAX = (POWERUP_WAIT > RESET_WAIT) ? POWERUP_WAIT : RESET_WAIT;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  sccb_state_t           state;
  logic [1:0]            quarter;
  logic [4:0]            bit_idx;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  soft_reset;
  logic                  tick;
  logic                  bus_active;

  assign bus_active = (state == START) || (state == BIT) || (state == STOP) || (state == GAP);

  sccb_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (!bus_active),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RESEND;
      advance    <= 1'b0;
      resend     <= 1'b0;
      sioc       <= 1'b1;
      siod_out   <= 1'b1;
      siod_oe    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      quarter    <= '0;
      bit_idx    <= '0;
      wait_cnt   <= '0;
      shreg      <= '0;
      soft_reset <= 1'b0;
    end else if (reconfig) begin
      // Abandon any frame in flight; the camera resyncs on the next START.
      state    <= RESEND;
      advance  <= 1'b0;
      resend   <= 1'b0;
      sioc     <= 1'b1;
      siod_out <= 1'b1;
      siod_oe  <= 1'b1;
      done     <= 1'b0;
      quarter  <= '0;
    end else begin
      advance <= 1'b0;
      resend  <= 1'b0;
      case (state)
        RESEND: begin
          resend   <= 1'b1;
          busy     <= 1'b1;
          wait_cnt <= WAIT_W'(POWERUP_WAIT - 1);
          state    <= PWR_WAIT;
        end

        PWR_WAIT: begin
          if (wait_cnt == '0) state <= LOAD;
          else                wait_cnt <= wait_cnt - 1'b1;
        end

        LOAD: begin
          quarter <= '0;
          if (command == END_CMD || finished) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            shreg      <= build_frame(DEV_ADDR, command);
            soft_reset <= (command[15:8] == COM7_ADDR) && command[7];
            state      <= START;
          end
        end

        START: begin
          if (tick) begin
            if (quarter == 2'd0) begin
              siod_out <= 1'b0;
              quarter  <= 2'd1;
            end else begin
              sioc    <= 1'b0;
              quarter <= 2'd0;
              bit_idx <= 5'(FRAME_BITS - 1);
              state   <= BIT;
            end
          end
        end

        BIT: begin
          if (tick) begin
            quarter <= quarter + 1'b1;
            case (quarter)
              2'd0: begin
                sioc     <= 1'b0;
                siod_out <= shreg[bit_idx];
                siod_oe  <= !is_ack_slot(bit_idx);
              end
              2'd2: sioc <= 1'b1;
              2'd3: begin
                if (bit_idx == '0) state <= STOP;
                else               bit_idx <= bit_idx - 1'b1;
              end
              default: ;
            endcase
          end
        end

        STOP: begin
          if (tick) begin
            case (quarter)
              2'd0: begin
                sioc     <= 1'b0;
                siod_out <= 1'b0;
                siod_oe  <= 1'b1;
                quarter  <= 2'd1;
              end
              2'd1: begin
                sioc    <= 1'b1;
                quarter <= 2'd2;
              end
              default: begin
                siod_out <= 1'b1;
                quarter  <= 2'd0;
                state    <= GAP;
              end
            endcase
          end
        end

        GAP: begin
          // advance is high for exactly the cycle before leaving, so the table has
          // stepped by the time LOAD samples command.
          if (advance) begin
            if (soft_reset) begin
              wait_cnt <= WAIT_W'(RESET_WAIT - 1);
              state    <= RST_WAIT;
            end else begin
              state <= LOAD;
            end
          end else if (tick) begin
            if (quarter == 2'd3) begin
              advance <= 1'b1;
              quarter <= 2'd0;
            end else begin
              quarter <= quarter + 1'b1;
            end
          end
        end

        RST_WAIT: begin
          if (wait_cnt == '0) state <= LOAD;
          else                wait_cnt <= wait_cnt - 1'b1;
        end

        DONE: begin
          sioc     <= 1'b1;
          siod_out <= 1'b1;
          siod_oe  <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b1;
        end

        default: state <= RESEND;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_sender.sv
// Scoreboard bench: the stimulus queues expected frames, a bus monitor decodes and checks them.
module tb_ov7670_sccb_sender;

  localparam int CLK_DIV = 3;
  localparam int PW      = 10;
  localparam int RW      = 20;
  localparam logic [26:0] OE_MASK = 27'b111111110_111111110_111111110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reconfig = 1'b0;
  logic [15:0] command;
  logic        finished;
  logic        advance, resend, sioc, siod_out, siod_oe, busy, done;

  always #5 clk = ~clk;

  ov7670_sccb_sender #(
    .CLK_DIV      (CLK_DIV),
    .DEV_ADDR     (8'h42),
    .POWERUP_WAIT (PW),
    .RESET_WAIT   (RW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .reconfig (reconfig),
    .command  (command),
    .finished (finished),
    .advance  (advance),
    .resend   (resend),
    .sioc     (sioc),
    .siod_out (siod_out),
    .siod_oe  (siod_oe),
    .busy     (busy),
    .done     (done)
  );

  // Combinational command table stepped by advance, rewound by resend.
  int unsigned tbl_idx = 0;
  function automatic logic [15:0] rom_at(input int unsigned i);
    case (i)
      0:       return 16'h3A04;
      1:       return 16'h1280;
      2:       return 16'h1204;
      default: return 16'hFFFF;
    endcase
  endfunction
  always @(posedge clk) begin
    if (resend)       tbl_idx <= 0;
    else if (advance) tbl_idx <= tbl_idx + 1;
  end
  assign command  = rom_at(tbl_idx);
  assign finished = (tbl_idx > 3);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor
  int   adv_cnt = 0, res_cnt = 0, bus_viol = 0, nedges = 0;
  logic prev_sioc = 1'b1, prev_siod = 1'b1, prev_oe = 1'b1;
  logic in_frame = 1'b0, skip = 1'b0;
  logic [26:0] fbits, foe;
  logic [23:0] exp_frame;

  always @(negedge clk) begin
    if (advance) adv_cnt++;
    if (resend)  res_cnt++;
    if (rst || reconfig) begin
      in_frame = 1'b0;
      skip     = 1'b1;
    end else if (skip) begin
      skip = 1'b0;
    end else begin
      if (prev_sioc && sioc && (prev_oe !== siod_oe)) bus_viol++;
      if (sioc && prev_sioc && siod_oe && prev_siod && !siod_out) begin
        in_frame = 1'b1;
        nedges   = 0;
        fbits    = '0;
        foe      = '0;
      end else if (in_frame && !prev_sioc && sioc) begin
        if (nedges < 27) begin
          fbits[26-nedges] = siod_oe ? siod_out : 1'b1;
          foe[26-nedges]   = siod_oe;
        end
        nedges++;
      end else if (in_frame && sioc && prev_sioc && !prev_siod && siod_out && siod_oe) begin
        in_frame = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {8'h0, fbits[26:19], fbits[17:10], fbits[8:1]}, 32'hFFFFFFFF);
        end else begin
          exp_frame = exp_q.pop_front();
          // 27 data clocks plus the SIOC rise that precedes STOP
          check("frame_sioc_edges", nedges, 28);
          check("frame_bytes", {fbits[26:19], fbits[17:10], fbits[8:1]}, exp_frame);
          check("frame_ack_release", foe, OE_MASK);
        end
      end
    end
    prev_sioc = sioc;
    prev_siod = siod_out;
    prev_oe   = siod_oe;
  end

  task automatic push_table();
    exp_q.push_back(24'h42_3A_04);
    exp_q.push_back(24'h42_12_80);
    exp_q.push_back(24'h42_12_04);
  endtask

  task automatic wait_adv(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (advance) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check({tag, "_advance_timeout"}, 0, 1);
  endtask

  task automatic wait_sioc_rises(input int n);
    int   seen;
    logic p;
    seen = 0;
    p = sioc;
    for (int i = 0; i < 1000 && seen < n; i++) begin
      @(negedge clk);
      if (!p && sioc) seen++;
      p = sioc;
    end
    if (seen < n) check("sioc_rise_timeout", seen, n);
  endtask

  task automatic run_sequence(input int t_res, input string tag);
    int t0, t1, t2, base, tdone;
    base = adv_cnt;
    wait_adv(tag, t0);
    check({tag, "_adv0_latency"}, t0 - t_res, 479);
    wait_adv(tag, t1);
    check({tag, "_adv1_interval"}, t1 - t0, 470);
    wait_adv(tag, t2);
    check({tag, "_adv2_interval_com7_reset"}, t2 - t1, 490);
    tdone = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        tdone = cyc;
        break;
      end
    end
    check({tag, "_done_latency"}, tdone - t2, 2);
    repeat (60) @(negedge clk);
    check({tag, "_idle_bus"}, {sioc, siod_out, siod_oe, busy, done}, 5'b11101);
    check({tag, "_advance_count"}, adv_cnt - base, 3);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic pulse_reconfig(input string tag, output int t_res);
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
    check({tag, "_abort_bus"}, {sioc, siod_out, siod_oe, done, resend}, 5'b11100);
    @(negedge clk);
    check({tag, "_resend"}, resend, 1'b1);
    t_res = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_res, lows, extra, base_res;

    // Reset release and power-up wait
    repeat (3) @(negedge clk);
    check("reset_vector", {advance, resend, sioc, siod_out, siod_oe, busy, done}, 7'b0011100);
    push_table();
    rst = 1'b0;
    @(negedge clk);
    check("a_resend_first_cycle", resend, 1'b1);
    t_res = cyc;
    lows = 0;
    extra = 0;
    repeat (PW) begin
      @(negedge clk);
      if (!sioc) lows++;
      if (resend) extra++;
    end
    check("a_sioc_quiet_during_powerup", lows, 0);
    check("a_resend_width", extra, 0);
    check("a_busy", busy, 1'b1);
    run_sequence(t_res, "a");

    // Restart from DONE, then abort mid-BIT and run to completion
    pulse_reconfig("b_restart", t_res);
    wait_sioc_rises(10);
    repeat (10) @(negedge clk);
    pulse_reconfig("b_midframe", t_res);
    push_table();
    run_sequence(t_res, "b");

    // rst and reconfig together in the middle of a frame
    pulse_reconfig("c_restart", t_res);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
    @(negedge clk);
    check("c_rst_reconfig_vector", {advance, resend, sioc, siod_out, siod_oe, busy, done}, 7'b0011100);
    base_res = res_cnt;
    push_table();
    rst = 1'b0;
    @(negedge clk);
    check("c_resend_after_release", resend, 1'b1);
    t_res = cyc;
    run_sequence(t_res, "c");
    check("c_single_resend", res_cnt - base_res, 1);

    check("bus_oe_change_while_sioc_high", bus_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
